imm_encoder: RTL and testbench

Pipelined RISC-V instruction immediate encoder: the inverse of the core's immediate generator. It accepts an instruction template with its immediate fields ignored, plus a format code and a 32-bit signed immediate. It checks that the immediate is representable, scatters its bits into the format's instruction fields, and emits the finished 32-bit instruction word. The block sits in the instruction-assembly / self-test path feeding instruction memory. It has valid/ready handshakes on both sides and a saturating error counter.

---
 rtl/imm_encoder.sv | 123 ++++++++++++
 tb/tb_imm_encoder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage RISC-V immediate encoder with range check and saturating error counter
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [31:0] in_base,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    input  logic        err_clr,
    output logic [15:0] err_count
);
    localparam logic [2:0] F_I = 3'd0, F_SH = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;

    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [31:0] s1_base;
    logic [31:0] s1_imm;
    logic        s1_adv;
    logic        s2_adv;
    logic        enc_err;
    logic [31:0] enc_mask;
    logic [31:0] enc_field;
    logic [31:0] enc_instr;
    logic        sext11;
    logic        sext12;
    logic        sext20;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Upper bits must be a pure sign extension of the field's top bit.
    assign sext11 = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
    assign sext12 = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
    assign sext20 = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

    always_comb begin
        enc_err   = 1'b0;
        enc_mask  = 32'h0000_0000;
        enc_field = 32'h0000_0000;
        case (s1_fmt)
            F_I: begin
                enc_err   = !sext11;
                enc_mask  = 32'hFFF0_0000;
                enc_field = {s1_imm[11:0], 20'b0};
            end
            F_SH: begin
                enc_err   = |s1_imm[31:5];
                enc_mask  = 32'h01F0_0000;
                enc_field = {7'b0, s1_imm[4:0], 20'b0};
            end
            F_S: begin
                enc_err   = !sext11;
                enc_mask  = 32'hFE00_0F80;
                enc_field = {s1_imm[11:5], 13'b0, s1_imm[4:0], 7'b0};
            end
            F_B: begin
                enc_err   = !sext12 || s1_imm[0];
                enc_mask  = 32'hFE00_0F80;
                enc_field = {s1_imm[12], s1_imm[10:5], 13'b0, s1_imm[4:1], s1_imm[11], 7'b0};
            end
            F_U: begin
                enc_err   = |s1_imm[11:0];
                enc_mask  = 32'hFFFF_F000;
                enc_field = {s1_imm[31:12], 12'b0};
            end
            F_J: begin
                enc_err   = !sext20 || s1_imm[0];
                enc_mask  = 32'hFFFF_F000;
                enc_field = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], 12'b0};
            end
            default: begin
                enc_err   = 1'b1;
                enc_mask  = 32'h0000_0000;
                enc_field = 32'h0000_0000;
            end
        endcase
        enc_instr = (s1_base & ~enc_mask) | (enc_err ? 32'h0000_0000 : enc_field);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= 3'd0;
            s1_base   <= 32'h0;
            s1_imm    <= 32'h0;
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_err   <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= enc_instr;
                    out_err   <= enc_err;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_fmt  <= in_fmt;
                    s1_base <= in_base;
                    s1_imm  <= in_imm;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= 16'h0;
        end else if (err_clr) begin
            err_count <= 16'h0;
        end else if (out_valid && out_ready && out_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder with bit-map reference model
module tb_imm_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = 3'd0;
    logic [31:0] in_base = 32'h0;
    logic [31:0] in_imm = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic        err_clr = 1'b0;
    logic [15:0] err_count;

    imm_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_base(in_base), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .err_clr(err_clr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] cnt_m = 16'h0;
    logic        hold = 1'b0;
    logic [31:0] hold_instr;
    logic        hold_err;
    logic        rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Which immediate bit lands in instruction bit i for a format; -1 means template bit.
    function automatic int src_bit(input int fmt, input int i);
        case (fmt)
            0: return (i >= 20) ? i - 20 : -1;
            1: return (i >= 20 && i <= 24) ? i - 20 : -1;
            2: return (i >= 25) ? i - 20 : ((i >= 7 && i <= 11) ? i - 7 : -1);
            3: begin
                if (i == 31) return 12;
                if (i >= 25) return i - 20;
                if (i >= 8 && i <= 11) return i - 7;
                if (i == 7) return 11;
                return -1;
            end
            4: return (i >= 12) ? i : -1;
            5: begin
                if (i == 31) return 20;
                if (i >= 21) return i - 20;
                if (i == 20) return 11;
                if (i >= 12) return i;
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    function automatic logic representable(input int fmt, input logic [31:0] imm);
        int v;
        v = $signed(imm);
        case (fmt)
            0, 2: return (v >= -2048) && (v <= 2047);
            1:    return imm < 32'd32;
            3:    return (v >= -4096) && (v <= 4094) && (imm[0] == 1'b0);
            4:    return (imm % 32'd4096) == 32'd0;
            5:    return (v >= -(1 << 20)) && (v <= (1 << 20) - 2) && (imm[0] == 1'b0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input int fmt, input logic [31:0] base, input logic [31:0] imm);
        exp_t r;
        logic ok;
        int   s;
        ok = representable(fmt, imm);
        for (int i = 0; i < 32; i++) begin
            s = src_bit(fmt, i);
            r.instr[i] = (s < 0) ? base[i] : (ok ? imm[s] : 1'b0);
        end
        r.err = !ok;
        return r;
    endfunction

    task automatic send(input int fmt, input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic exp_err);
        logic acc;
        exp_t e;
        acc = 1'b0;
        in_fmt   = fmt[2:0];
        in_base  = base;
        in_imm   = imm;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                e.instr = exp_instr;
                e.err   = exp_err;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_m(input int fmt, input logic [31:0] base, input logic [31:0] imm);
        exp_t e;
        e = model(fmt, base, imm);
        send(fmt, base, imm, e.instr, e.err);
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic inc;
        inc = 1'b0;
        if (reset) begin
            cnt_m = 16'h0;
            hold  = 1'b0;
        end else begin
            check("err_count", {16'h0, err_count}, {16'h0, cnt_m});
            if (hold) begin
                check("hold_valid", {31'h0, out_valid}, 32'd1);
                check("hold_instr", out_instr, hold_instr);
                check("hold_err", {31'h0, out_err}, {31'h0, hold_err});
            end
            hold       = out_valid && !out_ready;
            hold_instr = out_instr;
            hold_err   = out_err;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word actual=%h required=none", out_instr);
                end else begin
                    e = sb.pop_front();
                    check("out_instr", out_instr, e.instr);
                    check("out_err", {31'h0, out_err}, {31'h0, e.err});
                    inc = e.err;
                end
            end
            if (err_clr) cnt_m = 16'h0;
            else if (inc && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [31:0] imm;
        logic [31:0] base;
        int          fmt;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_err", {31'h0, out_err}, 32'd0);
        check("rst_err_count", {16'h0, err_count}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);

        send(0, 32'h0000_0093, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        check("lat_edge1", {31'h0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_edge2", {31'h0, out_valid}, 32'd1);
        send(3, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        send(3, 32'h0000_0063, 32'h0000_0003, 32'h0000_0063, 1'b1);
        drain();
        check("b_err_count", {16'h0, err_count}, 32'd1);
        send(5, 32'h0000_006F, 32'h0000_0008, 32'h0080_006F, 1'b0);
        send(4, 32'h0000_02B7, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        send(4, 32'h0000_02B7, 32'h1234_5001, 32'h0000_02B7, 1'b1);
        send(1, 32'h4000_5093, 32'h0000_0003, 32'h4030_5093, 1'b0);
        send(1, 32'h4000_5093, 32'h0000_0021, 32'h4000_5093, 1'b1);
        drain();

        out_ready = 1'b0;
        fork
            begin
                send_m(0, 32'h0000_0113, 32'h0000_0011);
                send_m(2, 32'h0000_2023, 32'hFFFF_F800);
                send_m(5, 32'h0000_00EF, 32'h000F_FFFE);
            end
        join_none
        repeat (5) @(posedge clk);
        #1;
        check("bp_in_ready", {31'h0, in_ready}, 32'd0);
        check("bp_buffered", 32'(sb.size()), 32'd2);
        out_ready = 1'b1;
        wait fork;
        drain();

        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            fmt  = $urandom_range(0, 7);
            base = $urandom;
            case ($urandom_range(0, 4))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm = $urandom & 32'h0000_003F;
                3: imm = 32'($urandom_range(0, (1 << 22) - 1)) - 32'h0020_0000;
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            send_m(fmt, base, imm);
        end
        rand_ready = 1'b0;
        #2;
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        send_m(0, 32'h0000_0013, 32'h0000_0005);
        send_m(4, 32'h0000_0037, 32'hABCD_E000);
        reset = 1'b1;
        sb.delete();
        #1;
        check("rst_mid_valid", {31'h0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("rst_flush", {31'h0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        for (int n = 0; n < 65540; n++) send(7, 32'(n), $urandom, 32'(n), 1'b1);
        drain();
        check("sat_count", {16'h0, err_count}, 32'h0000_FFFF);
        send(6, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_wins", {16'h0, err_count}, 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
